reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order commit buffer, 16 entries.
- Allocates a tag (rob_reorder) for each dispatched instruction and feeds that tag plus operand readiness/values to the RS.
- Captures results broadcast by the ALU and LSB, and retires entries in program order to the register file and LSB.
- Raises a flush when a branch retires with a mispredict.

Parameters:
ROB_SIZE, 16, number of entries (power of two).
TAG_W, 4, tag width = log2(ROB_SIZE).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = hold all state
issue_flag  in  1  dispatch one instruction this cycle
issue_rd  in  5  destination register (0 = none)
issue_type  in  2  0 = reg-write, 1 = branch, 2 = store
rob_full  out  1  no free entry
rob_reorder  out  TAG_W  tag that the next issue will receive (= tail)
q1_tag, q2_tag  in  TAG_W  operand tags queried by dispatch
q1_ready, q2_ready  out  1  queried entry busy and result ready
q1_val, q2_val  out  32  queried entry result
alu_ans_flag  in  1  ALU broadcast valid
alu_ans_reorder  in  TAG_W  ALU broadcast tag
alu_ans  in  32  ALU result
alu_mispred  in  1  branch result mispredicted (valid with alu_ans_flag)
alu_target  in  32  correct PC for a mispredicted branch
lsb_flag  in  1  LSB broadcast valid
lsb_reorder  in  TAG_W  LSB broadcast tag
lsb_val  in  32  load result
commit_flag  out  1  one-cycle retire pulse
commit_rd  out  5  retired destination register
commit_val  out  32  retired value
commit_reorder  out  TAG_W  retired tag
store_commit  out  1  retired entry is a store; LSB may write memory
flush_flag  out  1  one-cycle mispredict flush
flush_pc  out  32  redirect PC

Behaviour:
- State per entry: busy, ready, mispred, type, rd, value, target. Pointers head and tail (TAG_W bits, wrap mod ROB_SIZE). count (TAG_W+1 bits).
- Reset (rst high at posedge): all busy/ready cleared; head = tail = count = 0.
  - Registered outputs all 0: commit_flag, commit_rd, commit_val, commit_reorder, store_commit, flush_flag, flush_pc.
  - Reset mid-operation discards every entry.
- rdy low: no state change; commit_flag, store_commit, flush_flag driven 0.
- Combinational outputs:
  - rob_full = (count == ROB_SIZE).
  - rob_reorder = tail.
  - qN_ready = busy[qN_tag] & ready[qN_tag].
  - qN_val = value[qN_tag].
- Issue:
  - Accepted if issue_flag & !rob_full & !flush: entry[tail] gets busy = 1, ready = 0, mispred = 0, rd, type; tail increments.
  - Issue while full is ignored; no tag is consumed.
  - A store entry is written with ready = 1 at allocation.
- Writeback:
  - On alu_ans_flag, if busy[alu_ans_reorder]: set ready = 1, value = alu_ans, mispred = alu_mispred, target = alu_target.
  - On lsb_flag, if busy[lsb_reorder]: set ready = 1, value = lsb_val.
  - Broadcasts to non-busy entries are ignored.
  - Same tag on both buses in one cycle: ALU wins.
  - A broadcast to the entry being allocated in the same cycle is ignored.
- Commit (at most one per cycle): when busy[head] & ready[head], at the next edge:
  - commit_flag = 1; commit_rd = rd, or 0 for branch/store.
  - commit_val = value; commit_reorder = head.
  - store_commit = (type == store).
  - busy[head] cleared; head increments.
  - In any cycle without a commit, commit_flag = 0 and store_commit = 0.
- Flush:
  - If the committing entry has mispred = 1: same edge sets flush_flag = 1 and flush_pc = target.
  - All busy cleared; head = tail = count = 0.
  - A simultaneous issue is dropped. commit_flag is still 1 for the branch.
- count: +1 on issue, -1 on commit. Simultaneous issue and commit leave it unchanged. A full ROB can commit and issue in the same cycle only if the commit precedes (rob_full is evaluated before the edge, so the issue is rejected).

Optional Feature:
ROB_BYPASS_EN:
- Defined: the operand query also forwards a same-cycle broadcast. If a CDB flag is set with tag == qN_tag and the entry is busy, then qN_ready = 1 and qN_val = the bus value (ALU priority over LSB).
- Undefined: the query sees stored state only; the value becomes visible one cycle after the broadcast.

Test Plan:
1. Reset, then issue 3 reg-writes (rd = 1, 2, 3) -> rob_reorder goes 0, 1, 2, 3; count = 3; no commit_flag.
2. ALU broadcast tag 1 = 0x55 before tag 0, then tag 0 = 0x11 -> commits in order: tag 0 (rd 1, 0x11), then tag 1 (rd 2, 0x55), on consecutive cycles.
3. Issue 16 entries -> rob_full = 1; a 17th issue is ignored and tail stays 0. Commit one, then issue -> the new entry takes tag 0 (wrap).
4. Branch at tag 2 completes with alu_mispred = 1, alu_target = 0x100 -> at its commit, flush_flag = 1 and flush_pc = 0x100; rob_reorder = 0 and rob_full = 0 next cycle.
5. Hold rdy = 0 for 3 cycles with a ready head -> no commit and state frozen; the commit fires the cycle after rdy returns.
6. With ROB_BYPASS_EN defined, query q1_tag = 4 while lsb_flag carries tag 4 = 0xABCD -> q1_ready = 1 and q1_val = 0xABCD in the same cycle. Without it, q1_ready = 0 in that cycle.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular in-order commit buffer.
//
// Dispatch allocates one entry per accepted issue. The tag the entry receives
// is rob_reorder, which always equals the tail pointer. The ALU and LSB
// broadcast results by tag. Entries retire strictly in program order, at most
// one per cycle. A retiring branch that was mispredicted raises flush_flag,
// which empties the buffer.
//
// Optional feature (macro ROB_BYPASS_EN):
//   defined   - the operand queries also forward a same-cycle ALU/LSB
//               broadcast (the ALU wins when both carry the same tag).
//   undefined - the queries see stored state only.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   rdy                 global enable; when low, all state holds
//   issue_flag/rd/type  dispatch request (type 0 reg-write, 1 branch, 2 store)
//   rob_full            no free entry
//   rob_reorder         tag that the next accepted issue will receive
//   q1_/q2_tag          operand tags queried by dispatch
//   q1_/q2_ready, _val  queried entry is busy and ready, plus its value
//   alu_ans_*           ALU broadcast: tag, value, mispredict flag, target
//   lsb_*               LSB broadcast: tag, value
//   commit_*            one-cycle retire pulse with rd/value/tag
//   store_commit        the retired entry is a store
//   flush_flag/pc       one-cycle mispredict flush and its redirect PC
//
// Handshake semantics: every *_flag input is a single-cycle valid. It is
// consumed at the rising edge where it is high and rdy is high. There is no
// back-pressure, except that an issue is dropped while rob_full is high (as
// sampled before that edge) or while a flush retires at that edge. The
// commit_flag, store_commit and flush_flag outputs are registered pulses that
// are high for exactly one cycle per event.

module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_flag,
    input  logic [4:0]       issue_rd,
    input  logic [1:0]       issue_type,
    output logic             rob_full,
    output logic [TAG_W-1:0] rob_reorder,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_val,
    output logic [31:0]      q2_val,
    input  logic             alu_ans_flag,
    input  logic [TAG_W-1:0] alu_ans_reorder,
    input  logic [31:0]      alu_ans,
    input  logic             alu_mispred,
    input  logic [31:0]      alu_target,
    input  logic             lsb_flag,
    input  logic [TAG_W-1:0] lsb_reorder,
    input  logic [31:0]      lsb_val,
    output logic             commit_flag,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [TAG_W-1:0] commit_reorder,
    output logic             store_commit,
    output logic             flush_flag,
    output logic [31:0]      flush_pc
);

    localparam logic [1:0]     TYPE_BRANCH = 2'd1;
    localparam logic [1:0]     TYPE_STORE  = 2'd2;
    localparam logic [TAG_W:0] FULL_COUNT  = (TAG_W+1)'(ROB_SIZE);

    // Per-entry state.
    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] mispred;
    logic [1:0]          typ    [ROB_SIZE];
    logic [4:0]          rd_q   [ROB_SIZE];
    logic [31:0]         value  [ROB_SIZE];
    logic [31:0]         target [ROB_SIZE];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic commit_now;
    logic flush_now;
    logic issue_ok;

    assign rob_full    = (count == FULL_COUNT);
    assign rob_reorder = tail;

    // Every retire decision is made from the state before the edge. This is
    // why a full buffer that commits in some cycle still rejects an issue in
    // that same cycle.
    assign commit_now = busy[head] & ready[head];
    assign flush_now  = commit_now & mispred[head];
    assign issue_ok   = issue_flag & ~rob_full & ~flush_now;

    // Operand queries.
`ifdef ROB_BYPASS_EN
    logic q1_alu_hit, q1_lsb_hit, q2_alu_hit, q2_lsb_hit;

    assign q1_alu_hit = alu_ans_flag && (alu_ans_reorder == q1_tag);
    assign q1_lsb_hit = lsb_flag && (lsb_reorder == q1_tag);
    assign q2_alu_hit = alu_ans_flag && (alu_ans_reorder == q2_tag);
    assign q2_lsb_hit = lsb_flag && (lsb_reorder == q2_tag);

    assign q1_ready = busy[q1_tag] & (ready[q1_tag] | q1_alu_hit | q1_lsb_hit);
    assign q2_ready = busy[q2_tag] & (ready[q2_tag] | q2_alu_hit | q2_lsb_hit);
    assign q1_val   = q1_alu_hit ? alu_ans : (q1_lsb_hit ? lsb_val : value[q1_tag]);
    assign q2_val   = q2_alu_hit ? alu_ans : (q2_lsb_hit ? lsb_val : value[q2_tag]);
`else
    assign q1_ready = busy[q1_tag] & ready[q1_tag];
    assign q2_ready = busy[q2_tag] & ready[q2_tag];
    assign q1_val   = value[q1_tag];
    assign q2_val   = value[q2_tag];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= '0;
            ready          <= '0;
            mispred        <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_flag    <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_reorder <= '0;
            store_commit   <= 1'b0;
            flush_flag     <= 1'b0;
            flush_pc       <= '0;
        end else if (!rdy) begin
            commit_flag  <= 1'b0;
            store_commit <= 1'b0;
            flush_flag   <= 1'b0;
        end else begin
            commit_flag  <= commit_now;
            store_commit <= commit_now && (typ[head] == TYPE_STORE);
            flush_flag   <= flush_now;
            if (commit_now) begin
                commit_rd      <= (typ[head] == TYPE_BRANCH || typ[head] == TYPE_STORE)
                                  ? 5'd0 : rd_q[head];
                commit_val     <= value[head];
                commit_reorder <= head;
            end
            if (flush_now) begin
                flush_pc <= target[head];
            end

            // Writeback. The LSB write comes first so that the ALU write
            // overrides it when both buses carry the same tag. Only busy
            // entries accept a result. An entry allocated at this edge was
            // free before the edge, so a broadcast to it is dropped.
            if (lsb_flag && busy[lsb_reorder]) begin
                ready[lsb_reorder] <= 1'b1;
                value[lsb_reorder] <= lsb_val;
            end
            if (alu_ans_flag && busy[alu_ans_reorder]) begin
                ready[alu_ans_reorder]   <= 1'b1;
                value[alu_ans_reorder]   <= alu_ans;
                mispred[alu_ans_reorder] <= alu_mispred;
                target[alu_ans_reorder]  <= alu_target;
            end

            if (flush_now) begin
                busy    <= '0;
                ready   <= '0;
                mispred <= '0;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
            end else begin
                if (commit_now) begin
                    busy[head] <= 1'b0;
                    head       <= head + TAG_W'(1);
                end
                if (issue_ok) begin
                    busy[tail]    <= 1'b1;
                    // A store has nothing to wait for and can retire at once.
                    ready[tail]   <= (issue_type == TYPE_STORE);
                    mispred[tail] <= 1'b0;
                    typ[tail]     <= issue_type;
                    rd_q[tail]    <= issue_rd;
                    tail          <= tail + TAG_W'(1);
                end
                count <= count + (TAG_W+1)'(issue_ok) - (TAG_W+1)'(commit_now);
            end
        end
    end

endmodule
